// File: rtl/serial_add_arbiter.sv
// Two-requester round-robin front end for a single shared bit-serial full adder.
// Operands are added LSB-first, one bit per clock; the result is reported with a done pulse and requester ID.
module serial_add_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic [WIDTH-1:0] A0,
  input  logic [WIDTH-1:0] B0,
  input  logic             req1,
  input  logic [WIDTH-1:0] A1,
  input  logic [WIDTH-1:0] B1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic [WIDTH-1:0] Sum,
  output logic             Carry,
  output logic             done,
  output logic             done_id
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sr, b_sr, sum_sr;
  logic [CW-1:0]    count;
  logic             carry_ff;
  logic             cur_id;
  logic             last_served;

  logic             h1, c1, s, c2, carry_next;
  logic             pick1;
  logic [WIDTH-1:0] next_sum;

  // Stage 1 combines the operand bits; stage 2 folds in the stored carry.
  assign h1         = a_sr[0] ^ b_sr[0];
  assign c1         = a_sr[0] & b_sr[0];
  assign s          = h1 ^ carry_ff;
  assign c2         = h1 & carry_ff;
  assign carry_next = c1 | c2;
  assign next_sum   = {s, sum_sr[WIDTH-1:1]};

  // On a tie the requester that was not served last wins.
  assign pick1 = req1 & (~req0 | ~last_served);

  // NOTE: every register here is written with <= so all of them update from
  // the same pre-edge values; blocking writes would make the bit cell see a
  // half-updated carry and shift registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      done_id     <= 1'b0;
      Sum         <= '0;
      Carry       <= 1'b0;
      count       <= '0;
      carry_ff    <= 1'b0;
      cur_id      <= 1'b0;
      last_served <= 1'b1;
      // NOTE: the datapath shift registers are cleared as well; they are
      // never observable, but a known value keeps simulation X-free.
      a_sr        <= '0;
      b_sr        <= '0;
      sum_sr      <= '0;
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 | req1) begin
            a_sr     <= pick1 ? A1 : A0;
            b_sr     <= pick1 ? B1 : B0;
            carry_ff <= 1'b0;
            count    <= '0;
            gnt0     <= ~pick1;
            gnt1     <= pick1;
            busy     <= 1'b1;
            cur_id   <= pick1;
            state    <= RUN;
          end
        end
        RUN: begin
          a_sr     <= a_sr >> 1;
          b_sr     <= b_sr >> 1;
          sum_sr   <= next_sum;
          carry_ff <= carry_next;
          count    <= count + 1'b1;
          if (count == LAST_BIT) begin
            Sum         <= next_sum;
            Carry       <= carry_next;
            done        <= 1'b1;
            done_id     <= cur_id;
            last_served <= cur_id;
            busy        <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_arbiter.sv
// Self-checking bench for serial_add_arbiter: expected results are queued when
// stimulus is driven and compared by a monitor whenever done pulses.
module tb_serial_add_arbiter;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0 = 1'b0, req1 = 1'b0;
  logic [W-1:0] A0 = '0, B0 = '0, A1 = '0, B1 = '0;
  logic         gnt0, gnt1, busy, Carry, done, done_id;
  logic [W-1:0] Sum;

  typedef struct {
    logic         id;
    logic [W-1:0] sum;
    logic         carry;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic [W-1:0] last_sum = '0;
  logic         last_carry = 1'b0;

  serial_add_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .A0(A0), .B0(B0),
    .req1(req1), .A1(A1), .B1(B1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy),
    .Sum(Sum), .Carry(Carry), .done(done), .done_id(done_id)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Monitor: invariants every cycle, scoreboard compare on done.
  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if ((gnt0 && gnt1) || ((gnt0 || gnt1) && done)) begin
        errors++;
        $display("FAIL exclusive: gnt0=%b gnt1=%b done=%b", gnt0, gnt1, done);
      end
      if (done) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_done: id=%b Sum=%h Carry=%b, none expected", done_id, Sum, Carry);
        end else begin
          mon_e = sb.pop_front();
          if (done_id !== mon_e.id || Sum !== mon_e.sum || Carry !== mon_e.carry) begin
            errors++;
            $display("FAIL result: got id=%b Sum=%h Carry=%b, expected id=%b Sum=%h Carry=%b",
                     done_id, Sum, Carry, mon_e.id, mon_e.sum, mon_e.carry);
          end
        end
      end else begin
        checks++;
        if (Sum !== last_sum || Carry !== last_carry) begin
          errors++;
          $display("FAIL hold: Sum=%h Carry=%b changed without done, was %h %b",
                   Sum, Carry, last_sum, last_carry);
        end
      end
    end
    last_sum   = Sum;
    last_carry = Carry;
  end

  function automatic exp_t model(input logic id, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic [W:0] full;
    full    = {1'b0, a} + {1'b0, b};
    e.id    = id;
    e.sum   = full[W-1:0];
    e.carry = full[W];
    return e;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    req0 = 1'b0;
    req1 = 1'b0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 30);
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_timeout: done=%b after %0d cycles, required 1", tag, done, n);
    end
  endtask

  task automatic run_op(input logic id, input logic [W-1:0] a, input logic [W-1:0] b, input string tag);
    int n = 0;
    int bcnt;
    @(negedge clk);
    if (id) begin req1 = 1'b1; A1 = a; B1 = b; end
    else    begin req0 = 1'b1; A0 = a; B0 = b; end
    sb.push_back(model(id, a, b));
    do begin
      @(negedge clk);
      n++;
    end while (!(gnt0 || gnt1) && n < 20);
    checks++;
    if ({gnt1, gnt0} !== (id ? 2'b10 : 2'b01) || n != 1) begin
      errors++;
      $display("FAIL %s_gnt: gnt1,gnt0=%b after %0d cycles, required %b after 1",
               tag, {gnt1, gnt0}, n, id ? 2'b10 : 2'b01);
    end
    req0 = 1'b0;
    req1 = 1'b0;
    bcnt = busy ? 1 : 0;
    @(negedge clk);
    checks++;
    if (gnt0 || gnt1) begin
      errors++;
      $display("FAIL %s_gnt_pulse: gnt still high (%b%b), required 00", tag, gnt1, gnt0);
    end
    n = 0;
    while (busy && n < 30) begin
      bcnt++;
      @(negedge clk);
      n++;
    end
    checks++;
    if (bcnt != W || done !== 1'b1) begin
      errors++;
      $display("FAIL %s_latency: busy cycles=%0d done=%b, required %0d and 1", tag, bcnt, done, W);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if ({gnt0, gnt1, busy, done, done_id, Carry} !== 6'b0 || Sum !== '0) begin
        errors++;
        $display("FAIL reset_values: gnt0=%b gnt1=%b busy=%b done=%b id=%b Sum=%h Carry=%b, required all 0",
                 gnt0, gnt1, busy, done, done_id, Sum, Carry);
      end
      req0 = 1'($urandom);
      req1 = 1'($urandom);
      A0 = W'($urandom); B0 = W'($urandom);
      A1 = W'($urandom); B1 = W'($urandom);
    end
    @(negedge clk);
    req0 = 1'b0;
    req1 = 1'b0;
    #2 rst_n = 1'b1;
  endtask

  task automatic test_single();
    run_op(1'b0, 8'h5A, 8'h3C, "single");
  endtask

  task automatic test_overflow();
    run_op(1'b1, 8'hFF, 8'h01, "ovf_a");
    run_op(1'b0, 8'hFF, 8'hFF, "ovf_b");
    run_op(1'b1, 8'h00, 8'h00, "zero");
  endtask

  task automatic test_contention();
    int n = 0;
    apply_reset();
    @(negedge clk);
    req0 = 1'b1; A0 = 8'h12; B0 = 8'h34;
    req1 = 1'b1; A1 = 8'h80; B1 = 8'h80;
    sb.push_back(model(1'b0, 8'h12, 8'h34));
    sb.push_back(model(1'b1, 8'h80, 8'h80));
    do begin
      @(negedge clk);
      n++;
    end while (!(gnt0 || gnt1) && n < 20);
    checks++;
    if (gnt0 !== 1'b1 || gnt1 !== 1'b0) begin
      errors++;
      $display("FAIL contention_first: gnt0=%b gnt1=%b, required gnt0=1 gnt1=0", gnt0, gnt1);
    end
    req0 = 1'b0;
    wait_done("contention_op0");
    @(negedge clk);
    checks++;
    if (gnt1 !== 1'b1 || gnt0 !== 1'b0) begin
      errors++;
      $display("FAIL contention_second: gnt0=%b gnt1=%b one cycle after done, required gnt1=1", gnt0, gnt1);
    end
    req1 = 1'b0;
    wait_done("contention_op1");
  endtask

  task automatic test_back_to_back();
    int gcount = 0, dcount = 0, last_done = 0, n = 0;
    logic [W-1:0] a [4] = '{8'h01, 8'hC3, 8'h7F, 8'hAA};
    logic [W-1:0] b [4] = '{8'h02, 8'h3D, 8'h81, 8'h55};
    apply_reset();
    @(negedge clk);
    req0 = 1'b1; A0 = a[0]; B0 = b[0];
    req1 = 1'b1; A1 = a[1]; B1 = b[1];
    for (int k = 0; k < 4; k++) sb.push_back(model(1'(k % 2), a[k], b[k]));
    while (dcount < 4 && n < 100) begin
      @(negedge clk);
      n++;
      if (gnt0 || gnt1) begin
        checks++;
        if (gnt1 !== 1'(gcount % 2)) begin
          errors++;
          $display("FAIL fair_order: grant %0d went to %0d, required %0d", gcount, gnt1, gcount % 2);
        end
        gcount++;
        if (gcount == 2) begin A0 = a[2]; B0 = b[2]; end
        if (gcount == 3) begin A1 = a[3]; B1 = b[3]; end
        if (gcount == 4) begin req0 = 1'b0; req1 = 1'b0; end
      end
      if (done) begin
        if (dcount > 0) begin
          checks++;
          if (cyc - last_done != W + 1) begin
            errors++;
            $display("FAIL fair_gap: done spacing %0d cycles, required %0d", cyc - last_done, W + 1);
          end
        end
        last_done = cyc;
        dcount++;
      end
    end
    checks++;
    if (dcount != 4) begin
      errors++;
      $display("FAIL fair_count: %0d done pulses, required 4", dcount);
    end
  endtask

  task automatic test_reset_mid_op();
    int n = 0;
    @(negedge clk);
    req0 = 1'b1; A0 = 8'h99; B0 = 8'h99;
    do begin
      @(negedge clk);
      n++;
    end while (!gnt0 && n < 20);
    req0 = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (Sum !== '0 || Carry !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL midreset_clear: Sum=%h Carry=%b busy=%b done=%b, required all 0", Sum, Carry, busy, done);
    end
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    // No done may follow for the aborted op; the monitor flags any stray one.
    repeat (12) @(negedge clk);
    checks++;
    if (Sum !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_idle: Sum=%h busy=%b after abort, required 00 and 0", Sum, busy);
    end
    run_op(1'b0, 8'h6B, 8'hB7, "after_reset");
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_contention();
    test_back_to_back();
    test_reset_mid_op();
    repeat (3) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d results outstanding, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_add_arbiter.md
# serial_add_arbiter

Bit-serial adder controller that shares one full-adder bit cell (two half-adder stages plus a carry flip-flop) between two requesters. It arbitrates round-robin, latches the granted requester's operands, and adds them LSB-first, one bit per clock. It returns a WIDTH-bit Sum and a Carry with a one-cycle done pulse tagged with the requester ID. It sits between the lab's operand sources and the shared arithmetic resource, in place of a parallel adder per requester.

## Interface
- WIDTH, 8, operand and result width in bits (≥2).
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- req0  input  1  requester 0 request (level).
- A0, B0  input  WIDTH each  requester 0 operands; held stable while req0=1.
- req1  input  1  requester 1 request (level).
- A1, B1  input  WIDTH each  requester 1 operands; held stable while req1=1.
- gnt0, gnt1  output  1  one-cycle grant pulse; operands were captured at the same edge.
- busy  output  1  high from the grant edge until the done edge.
- Sum  output  WIDTH  result of the last completed add; held until the next done.
- Carry  output  1  carry-out of the last completed add.
- done  output  1  one-cycle pulse; Sum, Carry and done_id are valid in that cycle.
- done_id  output  1  requester served by the completing operation.

## Operation
- States: IDLE and RUN.
- IDLE, no request: all outputs hold, and gnt0, gnt1 and done stay 0.
- IDLE, at least one req high at an edge:
  - Select a requester. A single request wins outright.
  - If both are high, grant the one not equal to last_served.
  - Capture that requester's A/B into the shift registers. Clear the carry FF and the bit counter.
  - Set the matching gnt, set busy, set cur_id, and go to RUN.
- RUN, each edge processes bit i = counter, taking a = a_sr[0], b = b_sr[0], c = carry FF:
  - Stage 1: h1 = a^b, c1 = a&b.
  - Stage 2: s = h1^c, c2 = h1&c.
  - carry_next = c1|c2.
  - s shifts into the MSB of the internal sum_sr. a_sr and b_sr shift right. counter increments.
- When counter = WIDTH-1, that edge also does the following:
  - Sum ← final sum_sr, Carry ← carry_next.
  - done=1, done_id=cur_id, last_served=cur_id.
  - busy=0, and the state returns to IDLE.
- Requests during RUN are ignored, but not lost. A req still high in IDLE is arbitrated normally.
- A requester that keeps req high after its done is treated as a new request.
- The arithmetic is unsigned modulo 2^WIDTH. Carry is bit WIDTH of A+B.
- Sum and Carry change only at done edges. The internal shift registers are never visible on the outputs.

## Timing
- Reset values, applied asynchronously while rst_n=0:
  - state=IDLE, gnt0=gnt1=0, busy=0, done=0, done_id=0.
  - Sum=0, Carry=0, counter=0, carry FF=0.
  - last_served=1, so req0 wins the first tie.
- Latency: with the grant at edge E0, done is high in the cycle following edge E_WIDTH. That is WIDTH cycles after the grant pulse.
- Throughput: IDLE can accept a new request at edge E_WIDTH+1. Back-to-back operations therefore start every WIDTH+1 cycles.
- gnt and done are never high in the same cycle.
- At most one gnt is high in any cycle.
- Reset asserted mid-RUN aborts the operation: no done pulse, Sum and Carry return to 0, and after rst_n rises the block is in IDLE.
- A req that drops in the same cycle it would be sampled is simply not granted. There is no partial capture.

## Test plan
- Reset: hold rst_n=0 with random req and operand inputs. All outputs must stay at the reset values listed above, with no done pulse.
- Single op, WIDTH=8: req0=1, A0=0x5A, B0=0x3C. Require gnt0 for one cycle, busy for 8 cycles, then done=1 with Sum=0x96, Carry=0, done_id=0.
- Overflow: req1 with A1=0xFF, B1=0x01. Require Sum=0x00, Carry=1, done_id=1. Also A=0xFF, B=0xFF → Sum=0xFE, Carry=1.
- Contention: req0 and req1 raised on the same edge after reset, held until their respective grants. Require gnt0 first (done_id=0), then gnt1 one cycle after that done (done_id=1), with no overlap.
- Fairness: both reqs held continuously. Grants must alternate 0,1,0,1, and consecutive done pulses must be exactly 9 cycles apart.
- Reset mid-op: assert rst_n=0 at bit 4 of an add. Require no done pulse and Sum=0. A fresh request afterwards must complete with a correct result.
